// File: rtl/btn_debounce_bank.sv
// Purpose: N_CH independent button debouncers with press/release pulses and toggles.
// Latency: a clean input change reaches btn_level STL_CYCLES+1 edges after it is first sampled.
// Backpressure: none; the outputs are free-running status with no handshake.
//
// Ports:
//   clk         - single clock, all state updates on its rising edge
//   rst         - asynchronous active-high reset
//   btn_in      - raw asynchronous button pins, 1 = pressed
//   btn_level   - debounced stable level per channel
//   btn_press   - one-cycle pulse on each debounced 0->1 transition
//   btn_release - one-cycle pulse on each debounced 1->0 transition
//   btn_toggle  - level that inverts on every debounced press
//   btn_any     - OR of btn_press across channels, same cycle
module btn_debounce_bank #(
    parameter int N_CH       = 4,
    parameter int STL_CYCLES = 500000,
    parameter int CNT_W      = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_toggle,
    output logic            btn_any
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STL_CYCLES - 1);

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [N_CH-1:0]  s;
    logic [CNT_W-1:0] cnt [N_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            s           <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_toggle  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            for (int i = 0; i < N_CH; i++) begin
                btn_press[i]   <= 1'b0;
                btn_release[i] <= 1'b0;
                if (sync2[i] == s[i]) begin
                    // Input agrees with the stable state: any bounce restarts settling.
                    cnt[i] <= '0;
                end else if (cnt[i] >= CNT_MAX) begin
                    // Settled long enough; commit and fire the edge pulses on the same edge.
                    cnt[i]         <= '0;
                    s[i]           <= sync2[i];
                    btn_press[i]   <= sync2[i];
                    btn_release[i] <= ~sync2[i];
                    if (sync2[i]) begin
                        btn_toggle[i] <= ~btn_toggle[i];
                    end
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_level = s;
    assign btn_any   = |btn_press;

endmodule

// File: tb/tb_btn_debounce_bank.sv
module tb_btn_debounce_bank;

    localparam int N_CH = 4;
    localparam int STL  = 4;
    localparam int LAT  = STL + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_toggle;
    logic            btn_any;

    btn_debounce_bank #(.N_CH(N_CH), .STL_CYCLES(STL), .CNT_W(19)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle),
        .btn_any     (btn_any)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    typedef struct {
        int              at_edge;
        logic [N_CH-1:0] press;
        logic [N_CH-1:0] release_v;
        logic [N_CH-1:0] toggle;
        logic [N_CH-1:0] level;
    } ev_t;

    ev_t             sb[$];
    logic [N_CH-1:0] lvl_m = '0;
    logic [N_CH-1:0] tog_m = '0;

    // Expected debounced event, computed from the drive time and the settle latency.
    task automatic expect_ev(input int at_edge, input logic [N_CH-1:0] pr, input logic [N_CH-1:0] rl);
        ev_t e;
        lvl_m       = (lvl_m | pr) & ~rl;
        tog_m       = tog_m ^ pr;
        e.at_edge   = at_edge;
        e.press     = pr;
        e.release_v = rl;
        e.toggle    = tog_m;
        e.level     = lvl_m;
        sb.push_back(e);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer: every observed pulse must match the head of the queue.
    ev_t got_e;
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].at_edge < edge_cnt) begin
                chk("missed_event_edge", edge_cnt, sb[0].at_edge);
                void'(sb.pop_front());
            end
            if ((btn_press | btn_release) != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {btn_press, btn_release}, 0);
                end else begin
                    got_e = sb.pop_front();
                    chk("ev_edge",    edge_cnt,    got_e.at_edge);
                    chk("ev_press",   btn_press,   got_e.press);
                    chk("ev_release", btn_release, got_e.release_v);
                    chk("ev_toggle",  btn_toggle,  got_e.toggle);
                    chk("ev_level",   btn_level,   got_e.level);
                    chk("ev_any",     btn_any,     |got_e.press);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        btn_in = '0;
        ticks(3);
        chk("rst_level",   btn_level,   0);
        chk("rst_press",   btn_press,   0);
        chk("rst_release", btn_release, 0);
        chk("rst_toggle",  btn_toggle,  0);
        chk("rst_any",     btn_any,     0);
        rst = 1'b0;
        ticks(5);

        // Clean press and release on channel 0.
        btn_in[0] = 1'b1;
        expect_ev(edge_cnt + LAT, 4'b0001, 4'b0000);
        ticks(10);
        btn_in[0] = 1'b0;
        expect_ev(edge_cnt + LAT, 4'b0000, 4'b0001);
        ticks(10);

        // Channel 1 bounces: 3 high, 1 low, then held high.
        btn_in[1] = 1'b1;
        ticks(3);
        btn_in[1] = 1'b0;
        ticks(1);
        btn_in[1] = 1'b1;
        expect_ev(edge_cnt + LAT, 4'b0010, 4'b0000);
        ticks(12);
        btn_in[1] = 1'b0;
        expect_ev(edge_cnt + LAT, 4'b0000, 4'b0010);
        ticks(10);

        // Channel 2 press, release, press (10-cycle phases), then release.
        btn_in[2] = 1'b1;
        expect_ev(edge_cnt + LAT, 4'b0100, 4'b0000);
        ticks(10);
        btn_in[2] = 1'b0;
        expect_ev(edge_cnt + LAT, 4'b0000, 4'b0100);
        ticks(10);
        btn_in[2] = 1'b1;
        expect_ev(edge_cnt + LAT, 4'b0100, 4'b0000);
        ticks(10);
        chk("toggle2_after_2nd_press", btn_toggle[2], 1'b0);
        btn_in[2] = 1'b0;
        expect_ev(edge_cnt + LAT, 4'b0000, 4'b0100);
        ticks(10);

        // All channels at once.
        btn_in = 4'b1111;
        expect_ev(edge_cnt + LAT, 4'b1111, 4'b0000);
        ticks(10);
        btn_in = 4'b0000;
        expect_ev(edge_cnt + LAT, 4'b0000, 4'b1111);
        ticks(10);

        // Reset mid-settling on channel 3 while held.
        btn_in[3] = 1'b1;
        ticks(4);
        chk("cnt3_before_rst", dut.cnt[3], 2);
        rst = 1'b1;
        #1;
        chk("midrst_level",  btn_level,   0);
        chk("midrst_press",  btn_press,   0);
        chk("midrst_toggle", btn_toggle,  0);
        chk("midrst_any",    btn_any,     0);
        chk("midrst_cnt3",   dut.cnt[3],  0);
        lvl_m = '0;
        tog_m = '0;
        ticks(2);
        chk("midrst_release", btn_release, 0);
        rst = 1'b0;
        expect_ev(edge_cnt + LAT, 4'b1000, 4'b0000);
        ticks(10);

        // Long hold on channel 0: one press only, counter parked at 0.
        btn_in[0] = 1'b1;
        expect_ev(edge_cnt + LAT, 4'b0001, 4'b0000);
        ticks(10);
        for (int i = 0; i < 990; i++) begin
            ticks(1);
            if (i % 100 == 0) chk("hold_cnt0", dut.cnt[0], 0);
        end
        btn_in = 4'b0000;
        expect_ev(edge_cnt + LAT, 4'b0000, 4'b1001);
        ticks(12);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
